// File: rtl/adc_tx_scheduler.sv
// Round-robin packet scheduler: frames a granted 12-bit ADC sample into a 4-byte
// packet and feeds it byte-by-byte to the UART transmitter over a start/busy handshake.
module adc_tx_scheduler #(
    parameter int         ACK_TIMEOUT = 64,
    parameter logic [3:0] HEADER      = 4'hA
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [11:0] data0,
    input  logic [11:0] data1,
    output logic [1:0]  grant,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        baud_en,
    output logic        pkt_done,
    output logic        err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          last_ch, last_nxt;
    logic          ch, ch_nxt;
    logic [11:0]   sample, sample_nxt;
    logic [1:0]    grant_nxt;
    logic [7:0]    tx_data_nxt;
    logic          tx_start_nxt, baud_nxt, done_nxt, err_nxt;
    logic          pick;
    logic [7:0]    b0, b1, b2, b3, cur_byte;

    // On contention the channel that was not served last wins.
    assign pick = (req == 2'b11) ? ~last_ch : req[1];

    assign b0 = {HEADER, 3'b000, ch};
    assign b1 = {4'h0, sample[11:8]};
    assign b2 = sample[7:0];
    assign b3 = b0 ^ b1 ^ b2;

    always_comb begin
        case (idx)
            2'd0:    cur_byte = b0;
            2'd1:    cur_byte = b1;
            2'd2:    cur_byte = b2;
            default: cur_byte = b3;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        timer_nxt    = timer;
        last_nxt     = last_ch;
        ch_nxt       = ch;
        sample_nxt   = sample;
        grant_nxt    = 2'b00;
        tx_data_nxt  = tx_data;
        tx_start_nxt = 1'b0;
        baud_nxt     = baud_en;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    ch_nxt     = pick;
                    sample_nxt = pick ? data1 : data0;
                    grant_nxt  = pick ? 2'b10 : 2'b01;
                    baud_nxt   = 1'b1;
                    idx_nxt    = 2'd0;
                    state_nxt  = START;
                end
            end
            START: begin
                if (!tx_busy) begin
                    tx_data_nxt  = cur_byte;
                    tx_start_nxt = 1'b1;
                    timer_nxt    = '0;
                    state_nxt    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the packet.
                    err_nxt   = 1'b1;
                    baud_nxt  = 1'b0;
                    last_nxt  = ch;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx == 2'd3) begin
                        done_nxt  = 1'b1;
                        baud_nxt  = 1'b0;
                        last_nxt  = ch;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = START;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            timer    <= '0;
            last_ch  <= 1'b1;
            ch       <= 1'b0;
            sample   <= '0;
            grant    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            baud_en  <= 1'b0;
            pkt_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            timer    <= timer_nxt;
            last_ch  <= last_nxt;
            ch       <= ch_nxt;
            sample   <= sample_nxt;
            grant    <= grant_nxt;
            tx_data  <= tx_data_nxt;
            tx_start <= tx_start_nxt;
            baud_en  <= baud_nxt;
            pkt_done <= done_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_adc_tx_scheduler.sv
// Directed bench for adc_tx_scheduler: transmitter model, event monitor and one task per scenario.
module tb_adc_tx_scheduler;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [11:0] data0 = '0, data1 = '0;
    logic [1:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start, tx_busy, baud_en, pkt_done, err;

    int checks = 0, failures = 0;
    int cyc = 0;

    adc_tx_scheduler #(.ACK_TIMEOUT(64), .HEADER(4'hA)) dut (
        .clk_in(clk_in), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .grant(grant), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .baud_en(baud_en), .pkt_done(pkt_done), .err(err)
    );

    always #10 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Transmitter model: busy for 20 cycles after each tx_start.
    logic model_en = 1'b1, man_busy = 1'b0, model_busy = 1'b0;
    int   busy_cnt = 0;
    assign tx_busy = model_en ? model_busy : man_busy;

    always @(posedge clk_in) begin
        if (reset) begin
            busy_cnt   <= 0;
            model_busy <= 1'b0;
        end else if (model_en && tx_start) begin
            busy_cnt   <= 20;
            model_busy <= 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) model_busy <= 1'b0;
        end
    end

    // Event monitor, sampled on the falling edge.
    logic [7:0] bytes_q[$];
    int         start_cyc[$];
    logic [1:0] grants_q[$];
    int         grant_cyc[$];
    int         done_cyc[$];
    int         err_cyc[$];
    int         baud_bad = 0;
    logic       chk_baud = 1'b0, exp_baud = 1'b0, err_baud = 1'b1;

    always @(negedge clk_in) begin : mon
        logic e;
        if (tx_start) begin bytes_q.push_back(tx_data); start_cyc.push_back(cyc); end
        if (grant != 2'b00) begin grants_q.push_back(grant); grant_cyc.push_back(cyc); end
        if (pkt_done) done_cyc.push_back(cyc);
        if (err) begin err_cyc.push_back(cyc); err_baud <= baud_en; end
        e = exp_baud;
        if (!chk_baud) e = 1'b0;
        else begin
            if (grant != 2'b00) e = 1'b1;
            if (pkt_done || err) e = 1'b0;
            if (baud_en !== e) baud_bad <= baud_bad + 1;
        end
        exp_baud <= e;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive req until n grants are seen; optionally drop granted bits like a real requester.
    task automatic run_req(input logic [1:0] r, input int n, input bit drop, output bit ok);
        int g = 0;
        req = r;
        for (int i = 0; i < 2000 && g < n; i++) begin
            tick();
            if (grant != 2'b00) begin
                g++;
                if (drop) req = req & ~grant;
            end
        end
        req = 2'b00;
        ok = (g == n);
    endtask

    task automatic wait_ev(input int n_done, input int n_err, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done_cyc.size() >= n_done && err_cyc.size() >= n_err) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({grant, tx_data, tx_start, baud_en, pkt_done, err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {grant, tx_data, tx_start, baud_en, pkt_done, err});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] e[4];
        bit ok;
        int sb = bytes_q.size(), gb = grants_q.size(), db = done_cyc.size(), eb = err_cyc.size();
        e = '{8'hA0, 8'h0A, 8'hBC, 8'h16};
        chk_baud = 1'b1;
        data0 = 12'hABC;
        run_req(2'b01, 1, 1'b1, ok);
        wait_ev(db + 1, 0, 1000, ok);
        tick(); tick();
        checks++;
        if (!ok) begin failures++; $display("FAIL single_done_timeout got=0 want=1"); end
        checks++;
        if (grants_q.size() != gb + 1 || grants_q[gb] !== 2'b01) begin
            failures++; $display("FAIL single_grant got=%0d grants first=%b want=1 grant 01", grants_q.size() - gb, grants_q[gb]);
        end
        checks++;
        if (bytes_q.size() != sb + 4) begin
            failures++; $display("FAIL single_start_count got=%0d want=4", bytes_q.size() - sb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bytes_q[sb + i] !== e[i]) begin
                failures++; $display("FAIL single_byte%0d got=%h want=%h", i, bytes_q[sb + i], e[i]);
            end
        end
        checks++;
        if (start_cyc[sb] - grant_cyc[gb] != 1) begin
            failures++; $display("FAIL single_first_start_latency got=%0d want=1", start_cyc[sb] - grant_cyc[gb]);
        end
        checks++;
        if (done_cyc.size() != db + 1 || err_cyc.size() != eb) begin
            failures++; $display("FAIL single_done_err got=%0d/%0d want=1/0", done_cyc.size() - db, err_cyc.size() - eb);
        end
        checks++;
        if (baud_bad != 0) begin failures++; $display("FAIL single_baud_en got=%0d bad cycles want=0", baud_bad); end
    endtask

    task automatic test_contention();
        logic [7:0] e[8];
        bit ok;
        int sb, gb, db;
        e = '{8'hA0, 8'h0A, 8'hBC, 8'h16, 8'hA1, 8'h01, 8'h23, 8'h83};
        reset = 1'b1; tick(); reset = 1'b0; tick();
        sb = bytes_q.size(); gb = grants_q.size(); db = done_cyc.size();
        data0 = 12'hABC; data1 = 12'h123;
        run_req(2'b11, 2, 1'b1, ok);
        wait_ev(db + 2, 0, 2000, ok);
        tick();
        checks++;
        if (!ok) begin failures++; $display("FAIL contention_done_timeout got=0 want=1"); end
        checks++;
        if (grants_q[gb] !== 2'b01 || grants_q[gb + 1] !== 2'b10) begin
            failures++; $display("FAIL contention_grants got=%b,%b want=01,10", grants_q[gb], grants_q[gb + 1]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bytes_q[sb + i] !== e[i]) begin
                failures++; $display("FAIL contention_byte%0d got=%h want=%h", i, bytes_q[sb + i], e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gb = grants_q.size(), db = done_cyc.size();
        run_req(2'b11, 4, 1'b0, ok);
        wait_ev(db + 4, 0, 2000, ok);
        tick();
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_done_timeout got=0 want=1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grants_q[gb + i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL b2b_grant%0d got=%b want=%b", i, grants_q[gb + i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (grant_cyc[gb + i] - done_cyc[db + i - 1] != 1) begin
                failures++; $display("FAIL b2b_gap%0d got=%0d want=1", i, grant_cyc[gb + i] - done_cyc[db + i - 1]);
            end
        end
        checks++;
        if (baud_bad != 0) begin failures++; $display("FAIL b2b_baud_en got=%0d bad cycles want=0", baud_bad); end
    endtask

    task automatic test_timeout();
        bit ok;
        int sb = bytes_q.size(), gb, db = done_cyc.size(), eb = err_cyc.size();
        model_en = 1'b0; man_busy = 1'b0;
        data0 = 12'h456;
        run_req(2'b01, 1, 1'b1, ok);
        wait_ev(db, eb + 1, 300, ok);
        tick();
        checks++;
        if (!ok) begin failures++; $display("FAIL timeout_err_missing got=0 want=1"); end
        checks++;
        if (err_cyc[eb] - start_cyc[sb] != 64) begin
            failures++; $display("FAIL timeout_latency got=%0d want=64", err_cyc[eb] - start_cyc[sb]);
        end
        checks++;
        if (err_baud !== 1'b0 || baud_en !== 1'b0) begin
            failures++; $display("FAIL timeout_baud_en got=%b/%b want=0/0", err_baud, baud_en);
        end
        checks++;
        if (done_cyc.size() != db || bytes_q.size() != sb + 1) begin
            failures++; $display("FAIL timeout_activity got=done %0d starts %0d want=0/1", done_cyc.size() - db, bytes_q.size() - sb);
        end
        model_en = 1'b1;
        gb = grants_q.size();
        run_req(2'b11, 1, 1'b1, ok);
        wait_ev(db + 1, 0, 1000, ok);
        tick();
        checks++;
        if (grants_q[gb] !== 2'b10) begin
            failures++; $display("FAIL timeout_next_grant got=%b want=10", grants_q[gb]);
        end
        checks++;
        if (baud_bad != 0) begin failures++; $display("FAIL timeout_baud_track got=%0d bad cycles want=0", baud_bad); end
    endtask

    task automatic test_reset_midpacket();
        logic [7:0] e[4];
        bit ok;
        int sb = bytes_q.size(), db = done_cyc.size(), nb;
        e = '{8'hA0, 8'h03, 8'hC7, 8'h64};
        chk_baud = 1'b0;
        data0 = 12'h5A5;
        run_req(2'b01, 1, 1'b1, ok);
        for (int i = 0; i < 500 && bytes_q.size() < sb + 3; i++) tick();
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({grant, tx_data, tx_start, baud_en, pkt_done, err} !== 14'd0) begin
            failures++; $display("FAIL midreset_outputs got=%h want=0", {grant, tx_data, tx_start, baud_en, pkt_done, err});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (tx_start !== 1'b0 || pkt_done !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL midreset_after got=%b%b%b want=000", tx_start, pkt_done, err);
        end
        chk_baud = 1'b1;
        nb = bytes_q.size();
        data0 = 12'h3C7;
        run_req(2'b01, 1, 1'b1, ok);
        data0 = 12'hFFF;
        wait_ev(db + 1, 0, 1000, ok);
        tick();
        checks++;
        if (!ok || done_cyc.size() != db + 1) begin
            failures++; $display("FAIL midreset_done got=%0d want=1", done_cyc.size() - db);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bytes_q[nb + i] !== e[i]) begin
                failures++; $display("FAIL midreset_byte%0d got=%h want=%h", i, bytes_q[nb + i], e[i]);
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] e[4];
        bit ok;
        int sb = bytes_q.size(), db = done_cyc.size();
        e = '{8'hA0, 8'h00, 8'hF0, 8'h50};
        model_en = 1'b0; man_busy = 1'b1;
        data0 = 12'h0F0;
        run_req(2'b01, 1, 1'b1, ok);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bytes_q.size() != sb) begin
            failures++; $display("FAIL busyhold_withheld got=%0d starts want=0", bytes_q.size() - sb);
        end
        man_busy = 1'b0; model_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bytes_q.size() != sb + 1 || bytes_q[sb] !== 8'hA0) begin
            failures++; $display("FAIL busyhold_one_start got=%0d starts byte %h want=1 starts byte a0", bytes_q.size() - sb, bytes_q[sb]);
        end
        wait_ev(db + 1, 0, 1000, ok);
        tick();
        checks++;
        if (!ok || bytes_q.size() != sb + 4) begin
            failures++; $display("FAIL busyhold_packet got=%0d starts want=4", bytes_q.size() - sb);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (bytes_q[sb + i] !== e[i]) begin
                failures++; $display("FAIL busyhold_byte%0d got=%h want=%h", i, bytes_q[sb + i], e[i]);
            end
        end
        checks++;
        if (baud_bad != 0) begin failures++; $display("FAIL busyhold_baud_en got=%0d bad cycles want=0", baud_bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_midpacket();
        test_busy_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
